// File: rtl/rpm_pkg.sv
// Shared definitions for the RPM display path: default widths, converter
// state encoding and elaboration-time helpers for the BCD converter.
package rpm_pkg;

  localparam int RPM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // 10^n as a 64-bit constant; DIGITS tops out at 10, so this never overflows.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int bin_width, input int digits);
    return (bin_width >= 4) && (bin_width <= 32) && (digits >= 1) && (digits <= 10);
  endfunction

endpackage

// File: rtl/bcd_conv_if.sv
// Handshake and result bundle between the RPM computation, the BCD converter
// and the 7-segment digit drivers.
interface bcd_conv_if
  import rpm_pkg::*;
#(
  parameter int BIN_WIDTH = RPM_WIDTH,
  parameter int DIGITS    = 4
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_WIDTH-1:0]  in_bin;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   out_digits;
  logic [DIGITS-1:0]     out_blank;
  logic                  out_ovf;

  modport master (
    output in_valid,
    output in_bin,
    input  in_ready,
    input  out_valid,
    input  out_digits,
    input  out_blank,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    output in_ready,
    output out_valid,
    output out_digits,
    output out_blank,
    output out_ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Shift-and-add-3 correction for one BCD digit: values 5..15 get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with leading-zero
// blanking mask and saturating overflow for the RPM display.
module bcd_conv
  import rpm_pkg::*;
#(
  parameter int BIN_WIDTH = RPM_WIDTH,
  parameter int DIGITS    = 4
) (
  input logic       clk,
  input logic       rst,
  bcd_conv_if.slave bus
);

  localparam int SRW   = 4 * DIGITS + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
  // When every BIN_WIDTH-bit value fits in DIGITS digits, overflow can never occur.
  localparam bit HAS_OVF = (pow10(DIGITS) <= (64'd1 << BIN_WIDTH));
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  localparam bit PARAMS_OK = params_legal(BIN_WIDTH, DIGITS);

  conv_state_t state, state_next;

  logic                 ready;
  logic                 load;
  logic                 shift_en;
  logic                 finish;
  logic                 ovf_in;
  logic                 ovf_flag;
  logic [CNT_W-1:0]     cnt;
  logic [SRW-1:0]       sr;
  logic [SRW-1:0]       shift_in;
  logic [4*DIGITS-1:0]  scratch_adj;
  logic [4*DIGITS-1:0]  digits_next;
  logic [DIGITS-1:0]    blank_next;
  logic                 zeros_above;

  logic [4*DIGITS-1:0]  digits_q;
  logic [DIGITS-1:0]    blank_q;
  logic                 ovf_q;
  logic                 valid_q;

  always_ff @(posedge clk) begin
    assert (PARAMS_OK) else $error("bcd_conv: BIN_WIDTH must be 4..32 and DIGITS 1..10");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_ready depends only on state and rst so upstream never sees a loop through in_valid.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~rst;
        if (bus.in_valid && !rst) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == LAST_SHIFT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready = ready;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (sr[BIN_WIDTH + 4*g +: 4]),
      .adjusted (scratch_adj[4*g +: 4])
    );
  end

  assign ovf_in      = HAS_OVF && (64'(bus.in_bin) > MAX_VAL);
  assign shift_in    = {scratch_adj, sr[BIN_WIDTH-1:0]};
  assign digits_next = ovf_flag ? {DIGITS{4'h9}} : sr[SRW-1:BIN_WIDTH];

  // Walk from the most significant digit down; a digit blanks only while all above it are zero.
  always_comb begin
    blank_next  = '0;
    zeros_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_above   = zeros_above && (digits_next[4*i +: 4] == 4'd0);
      blank_next[i] = zeros_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      digits_q <= '0;
      blank_q  <= BLANK_RST;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load) begin
        sr       <= SRW'(bus.in_bin);
        cnt      <= '0;
        ovf_flag <= ovf_in;
      end
      if (shift_en) begin
        sr  <= shift_in << 1;
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        digits_q <= digits_next;
        blank_q  <= blank_next;
        ovf_q    <= ovf_flag;
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.out_digits = digits_q;
  assign bus.out_blank  = blank_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_bcd_conv.sv
// Self-checking bench for bcd_conv at three sizes (16/4, 8/3, 20/6) against
// a decimal-arithmetic reference model.
module tb_bcd_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   num_tests  = 0;
  int   num_failed = 0;

  always #5 clk = ~clk;

  bcd_conv_if #(.BIN_WIDTH(16), .DIGITS(4)) bus16 ();
  bcd_conv_if #(.BIN_WIDTH(8),  .DIGITS(3)) bus8 ();
  bcd_conv_if #(.BIN_WIDTH(20), .DIGITS(6)) bus20 ();

  bcd_conv #(.BIN_WIDTH(16), .DIGITS(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  bcd_conv #(.BIN_WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  bcd_conv #(.BIN_WIDTH(20), .DIGITS(6)) dut20 (.clk(clk), .rst(rst), .bus(bus20.slave));

  typedef struct {
    int               sel;
    longint unsigned  value;
    logic [39:0]      digits;
    logic [9:0]       blank;
    logic             ovf;
  } vec_t;

  vec_t vectors[11];

  function automatic int expLatency(input int sel);
    case (sel)
      0:       return 17;
      1:       return 9;
      default: return 21;
    endcase
  endfunction

  function automatic int digitsOf(input int sel);
    case (sel)
      0:       return 4;
      1:       return 3;
      default: return 6;
    endcase
  endfunction

  function automatic logic readyOf(input int sel);
    case (sel)
      0:       return bus16.in_ready;
      1:       return bus8.in_ready;
      default: return bus20.in_ready;
    endcase
  endfunction

  function automatic logic validOf(input int sel);
    case (sel)
      0:       return bus16.out_valid;
      1:       return bus8.out_valid;
      default: return bus20.out_valid;
    endcase
  endfunction

  // Decimal reference: saturate to 10^d-1, split by division, blank digits above the value.
  function automatic void refModel(input longint unsigned v, input int d,
                                   output logic [39:0] digits, output logic [9:0] blank,
                                   output logic ovf);
    longint unsigned maxv;
    longint unsigned sat;
    longint unsigned p;
    maxv = 1;
    for (int i = 0; i < d; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    ovf    = (v > maxv);
    sat    = ovf ? maxv : v;
    digits = '0;
    blank  = '0;
    p      = 1;
    for (int i = 0; i < d; i++) begin
      digits[4*i +: 4] = 4'((sat / p) % 10);
      if (i >= 1 && sat < p) blank[i] = 1'b1;
      p = p * 10;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    num_tests++;
    if (actual !== expected) begin
      num_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    num_tests++;
    num_failed++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic driveIn(input int sel, input logic valid, input longint unsigned value);
    case (sel)
      0:       begin bus16.in_valid = valid; bus16.in_bin = 16'(value); end
      1:       begin bus8.in_valid  = valid; bus8.in_bin  = 8'(value);  end
      default: begin bus20.in_valid = valid; bus20.in_bin = 20'(value); end
    endcase
  endtask

  task automatic readOut(input int sel, output logic [39:0] d, output logic [9:0] b, output logic o);
    case (sel)
      0:       begin d = 40'(bus16.out_digits); b = 10'(bus16.out_blank); o = bus16.out_ovf; end
      1:       begin d = 40'(bus8.out_digits);  b = 10'(bus8.out_blank);  o = bus8.out_ovf;  end
      default: begin d = 40'(bus20.out_digits); b = 10'(bus20.out_blank); o = bus20.out_ovf; end
    endcase
  endtask

  task automatic applyStimulus(input int sel, input longint unsigned value,
                               output logic [39:0] digits, output logic [9:0] blank,
                               output logic ovf, output int latency, output logic ready_at_valid);
    int wait_cnt;
    wait_cnt       = 0;
    digits         = '0;
    blank          = '0;
    ovf            = 1'b0;
    latency        = -1;
    ready_at_valid = 1'b0;
    @(negedge clk);
    while (!readyOf(sel) && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!readyOf(sel)) reportTimeout("in_ready");
    driveIn(sel, 1'b1, value);
    @(posedge clk);
    @(negedge clk);
    driveIn(sel, 1'b0, value);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (validOf(sel)) begin
        latency        = k;
        ready_at_valid = readyOf(sel);
        readOut(sel, digits, blank, ovf);
        break;
      end
    end
  endtask

  task automatic runVector(input int sel, input longint unsigned value, input logic [39:0] exp_digits,
                           input logic [9:0] exp_blank, input logic exp_ovf, input string name);
    logic [39:0] d;
    logic [9:0]  b;
    logic        o;
    int          lat;
    logic        rdy;
    applyStimulus(sel, value, d, b, o, lat, rdy);
    checkOutput({name, " latency"}, 64'(lat), 64'(expLatency(sel)));
    checkOutput({name, " digits"}, 64'(d), 64'(exp_digits));
    checkOutput({name, " blank"}, 64'(b), 64'(exp_blank));
    checkOutput({name, " ovf"}, 64'(o), 64'(exp_ovf));
    checkOutput({name, " ready_at_valid"}, 64'(rdy), 64'd1);
    @(negedge clk);
    checkOutput({name, " pulse_width"}, 64'(validOf(sel)), 64'd0);
  endtask

  task automatic runRandom(input int sel, input longint unsigned value, input string name);
    logic [39:0] d;
    logic [9:0]  b;
    logic        o;
    refModel(value, digitsOf(sel), d, b, o);
    runVector(sel, value, d, b, o, $sformatf("%s v=%0d", name, value));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int               acc[$];
    logic [39:0]      outs[$];
    logic [39:0]      d;
    logic [9:0]       b;
    logic             o;
    int               saw_valid;
    longint unsigned  v;

    driveIn(0, 1'b0, 0);
    driveIn(1, 1'b0, 0);
    driveIn(2, 1'b0, 0);

    vectors[0]  = '{0, 1234,    40'h1234,   10'b0000,   1'b0};
    vectors[1]  = '{0, 0,       40'h0000,   10'b1110,   1'b0};
    vectors[2]  = '{0, 7,       40'h0007,   10'b1110,   1'b0};
    vectors[3]  = '{0, 40,      40'h0040,   10'b1100,   1'b0};
    vectors[4]  = '{0, 9999,    40'h9999,   10'b0000,   1'b0};
    vectors[5]  = '{0, 10000,   40'h9999,   10'b0000,   1'b1};
    vectors[6]  = '{0, 65535,   40'h9999,   10'b0000,   1'b1};
    vectors[7]  = '{0, 500,     40'h0500,   10'b1000,   1'b0};
    vectors[8]  = '{1, 255,     40'h255,    10'b000,    1'b0};
    vectors[9]  = '{2, 999999,  40'h999999, 10'b000000, 1'b0};
    vectors[10] = '{2, 1000000, 40'h999999, 10'b000000, 1'b1};

    // Reset values on all three instances
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    readOut(0, d, b, o);
    checkOutput("rst16 digits", 64'(d), 64'd0);
    checkOutput("rst16 blank", 64'(b), 64'b1110);
    checkOutput("rst16 ovf", 64'(o), 64'd0);
    checkOutput("rst16 valid", 64'(bus16.out_valid), 64'd0);
    checkOutput("rst16 ready_in_reset", 64'(bus16.in_ready), 64'd0);
    readOut(1, d, b, o);
    checkOutput("rst8 blank", 64'(b), 64'b110);
    readOut(2, d, b, o);
    checkOutput("rst20 blank", 64'(b), 64'b111110);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", 64'(bus16.in_ready), 64'd1);

    foreach (vectors[i]) begin
      runVector(vectors[i].sel, vectors[i].value, vectors[i].digits, vectors[i].blank,
                vectors[i].ovf, $sformatf("vec%0d", i));
    end

    // Back-to-back: in_valid held, in_bin changes after the first accept
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.in_bin   = 16'd1;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) @(negedge clk);
      if (bus16.out_valid) outs.push_back(40'(bus16.out_digits));
      if (acc.size() >= 1) bus16.in_bin = 16'd2;
      if (acc.size() >= 2) bus16.in_valid = 1'b0;
      if (bus16.in_ready && bus16.in_valid) acc.push_back(c);
    end
    bus16.in_valid = 1'b0;
    checkOutput("b2b accept_count", 64'(acc.size()), 64'd2);
    checkOutput("b2b accept_spacing", 64'((acc.size() >= 2) ? (acc[1] - acc[0]) : 0), 64'd18);
    checkOutput("b2b result_count", 64'(outs.size()), 64'd2);
    checkOutput("b2b first", (outs.size() >= 1) ? 64'(outs[0]) : 64'hdead, 64'h0001);
    checkOutput("b2b second", (outs.size() >= 2) ? 64'(outs[1]) : 64'hdead, 64'h0002);

    // Reset in the middle of a conversion
    runVector(0, 8888, 40'h8888, 10'b0000, 1'b0, "pre_rst");
    @(negedge clk);
    driveIn(0, 1'b1, 4321);
    @(posedge clk);
    @(negedge clk);
    driveIn(0, 1'b0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst ready_in_reset", 64'(bus16.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    readOut(0, d, b, o);
    checkOutput("midrst digits", 64'(d), 64'd0);
    checkOutput("midrst blank", 64'(b), 64'b1110);
    checkOutput("midrst ovf", 64'(o), 64'd0);
    checkOutput("midrst valid", 64'(bus16.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("midrst ready_after", 64'(bus16.in_ready), 64'd1);
    saw_valid = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus16.out_valid) saw_valid++;
    end
    checkOutput("midrst no_out_valid", 64'(saw_valid), 64'd0);
    runVector(0, 4321, 40'h4321, 10'b0000, 1'b0, "post_rst");

    // Randomised checks against the reference model
    for (int i = 0; i < 20; i++) begin
      v = ($urandom % 2 == 0) ? longint'($urandom_range(0, 9999)) : longint'($urandom_range(0, 65535));
      runRandom(0, v, "rand16");
    end
    for (int i = 0; i < 10; i++) begin
      v = longint'($urandom_range(0, 1048575));
      runRandom(2, v, "rand20");
    end

    // Exhaustive sweep of the 8-bit instance
    for (int i = 0; i < 256; i++) begin
      runRandom(1, longint'(i), "sweep8");
    end

    $display("[TB] %0d tests run, %0d failed", num_tests, num_failed);
    $finish;
  end

endmodule
